lj16_frame_capture: RTL and testbench
=====================================

LJ16_FRAME_CAPTURE -- requirements
Module: lj16_frame_capture

Interface
REQ-001 SHALL have port: bck  input  1  bit clock of the 16-bit left-justified stream; all logic on its rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: lrck  input  1  word clock; 1 = left channel, 0 = right channel.
REQ-004 SHALL have port: data  input  1  serial sample data, MSB first, valid at bck rising edge.
REQ-005 SHALL have port: frame_l  output  16  captured left sample, two's complement.
REQ-006 SHALL have port: frame_r  output  16  captured right sample, two's complement.
REQ-007 SHALL have port: frame_valid  output  1  frame_l/frame_r hold an unconsumed frame.
REQ-008 SHALL have port: frame_ready  input  1  consumer accepts the frame when high with frame_valid high.
REQ-009 SHALL have port: locked  output  1  high while the block is aligned to the stream.
REQ-010 SHALL have port: sync_err  output  1  one-cycle pulse on a framing violation.
REQ-011 SHALL have port: overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-012 SHALL have port: mute  output  1  silence indicator (see Configuration).

Function
REQ-013 SHALL register lrck every cycle as lrck_d; an lrck edge is lrck != lrck_d, and the data bit sampled in that cycle is the MSB (bit 15) of the new channel.
REQ-014 SHALL implement states SYNC, LEFT, RIGHT; SYNC is entered from reset.
REQ-015 In SYNC, SHALL ignore data until a 0->1 lrck edge, then go to LEFT with the MSB captured and the bit count = 1.
REQ-016 In LEFT, SHALL shift in one bit per cycle MSB-first; after 16 bits, a 1->0 edge moves to RIGHT with the MSB captured.
REQ-017 In RIGHT, after 16 bits, a 0->1 edge SHALL complete the frame and move to LEFT, capturing the new left MSB in the same cycle.
REQ-018 Short channel (opposite-polarity edge before 16 bits): SHALL pulse sync_err, discard the partial frame, and go to SYNC; if the edge is 0->1, SHALL instead resync directly into LEFT with the MSB captured.
REQ-019 Long channel (17th bit without an edge): SHALL pulse sync_err, discard the partial frame, and go to SYNC.
REQ-020 A frame completes in the cycle its right LSB (16th right bit) is sampled; the holding register SHALL load in that cycle if frame_valid is 0 or frame_ready is 1, with frame_valid high from the next cycle.
REQ-021 If a frame completes while frame_valid=1 and frame_ready=0, SHALL keep the held frame, drop the new one, and pulse overrun.
REQ-022 frame_valid SHALL clear the cycle after frame_ready=1 unless a new frame loads in that same cycle.
REQ-023 frame_l/frame_r SHALL be stable while frame_valid=1 and frame_ready=0.
REQ-024 locked SHALL be 1 in LEFT/RIGHT after the first completed frame and 0 in SYNC.
REQ-025 In SYNC, frame_valid and a held frame SHALL persist until consumed.

Reset
REQ-026 On rst_n low, SHALL asynchronously clear frame_l, frame_r, frame_valid, locked, sync_err, overrun, mute, the bit count, the shift register, and lrck_d, and enter SYNC.
REQ-027 Reset mid-frame SHALL discard the partial frame; after release, capture SHALL restart only on the next 0->1 lrck edge.

Configuration
REQ-028 With LJ16_MUTE_DETECT_EN defined, SHALL count consecutive completed frames whose left and right are both 0x0000, set mute on the 64th such frame, and clear mute and the count on the first non-zero completed frame (dropped frames still count).
REQ-029 Without LJ16_MUTE_DETECT_EN, the mute port SHALL exist and be tied to 0, and no counter logic SHALL be present.

Verification
REQ-030 Reset, then lrck 0, then L=0x8001, R=0x7FFE with frame_ready=1 -> frame_valid pulses one cycle after R LSB with frame_l=0x8001, frame_r=0x7FFE; locked=1.
REQ-031 Two frames (0x1234/0x5678, then 0xAAAA/0x5555) with frame_ready=0 -> first frame held, overrun pulses once; frame_ready=1 -> frame_valid clears next cycle.
REQ-032 Right channel truncated to 12 bits, then a 0->1 edge -> sync_err pulses, no frame output, next full frame 0x0F0F/0xF0F0 is captured correctly.
REQ-033 lrck held high for 20 bck -> sync_err on the 17th bit, locked=0, and the state stays SYNC until a 0->1 edge.
REQ-034 rst_n low at left bit 8 -> all outputs 0 immediately; after release, a full frame 0x0001/0x0002 is captured.
REQ-035 With LJ16_MUTE_DETECT_EN, 64 zero frames -> mute=1 after the 64th; one frame 0x0000/0x0001 -> mute=0.

Source files
------------

// File: rtl/lj16_frame_capture.sv
// Left-justified 16-bit serial frame capture with framing checks and a holding register.
// Optional silence detector enabled by defining LJ16_MUTE_DETECT_EN.
module lj16_frame_capture (
    input  logic        bck,
    input  logic        rst_n,
    input  logic        lrck,
    input  logic        data,
    input  logic        frame_ready,
    output logic [15:0] frame_l,
    output logic [15:0] frame_r,
    output logic        frame_valid,
    output logic        locked,
    output logic        sync_err,
    output logic        overrun,
    output logic        mute
);

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_lrck_d;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_nxt;
    logic [31:0] r_sr;
    logic [31:0] w_sr_nxt;
    logic [15:0] r_frame_l;
    logic [15:0] r_frame_r;
    logic        r_valid;
    logic        r_locked;
    logic        r_sync_err;
    logic        r_overrun;
    logic        w_err;
    logic        w_done;
    logic        w_load;
    logic        w_rise;
    logic        w_fall;
    logic        w_edge;
    logic        w_full;

    assign w_rise = lrck & ~r_lrck_d;
    assign w_fall = ~lrck & r_lrck_d;
    assign w_edge = w_rise | w_fall;
    assign w_full = (r_cnt == 5'd16);
    assign w_load = w_done & (~r_valid | frame_ready);

    // Every edge samples the MSB of the new channel, so a good edge
    // or a 0->1 resync both restart the bit count at one.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sr_nxt    = r_sr;
        w_err       = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            SYNC: begin
                if (w_rise) begin
                    w_state_nxt = LEFT;
                    w_cnt_nxt   = 5'd1;
                    w_sr_nxt    = {31'd0, data};
                end
            end
            LEFT: begin
                if (w_edge) begin
                    if (w_full && w_fall) begin
                        w_state_nxt = RIGHT;
                        w_cnt_nxt   = 5'd1;
                        w_sr_nxt    = {r_sr[30:0], data};
                    end else begin
                        w_err = 1'b1;
                        if (w_rise) begin
                            w_state_nxt = LEFT;
                            w_cnt_nxt   = 5'd1;
                            w_sr_nxt    = {31'd0, data};
                        end else begin
                            w_state_nxt = SYNC;
                            w_cnt_nxt   = 5'd0;
                            w_sr_nxt    = 32'd0;
                        end
                    end
                end else if (w_full) begin
                    w_err       = 1'b1;
                    w_state_nxt = SYNC;
                    w_cnt_nxt   = 5'd0;
                    w_sr_nxt    = 32'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                    w_sr_nxt  = {r_sr[30:0], data};
                end
            end
            RIGHT: begin
                if (w_edge) begin
                    if (!(w_full && w_rise)) begin
                        w_err = 1'b1;
                    end
                    if (w_rise) begin
                        w_state_nxt = LEFT;
                        w_cnt_nxt   = 5'd1;
                        w_sr_nxt    = {31'd0, data};
                    end else begin
                        w_state_nxt = SYNC;
                        w_cnt_nxt   = 5'd0;
                        w_sr_nxt    = 32'd0;
                    end
                end else if (w_full) begin
                    w_err       = 1'b1;
                    w_state_nxt = SYNC;
                    w_cnt_nxt   = 5'd0;
                    w_sr_nxt    = 32'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                    w_sr_nxt  = {r_sr[30:0], data};
                    w_done    = (r_cnt == 5'd15);
                end
            end
            default: begin
                w_state_nxt = SYNC;
                w_cnt_nxt   = 5'd0;
                w_sr_nxt    = 32'd0;
            end
        endcase
    end

    always_ff @(posedge bck or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= SYNC;
            r_lrck_d <= 1'b0;
            r_cnt    <= 5'd0;
            r_sr     <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_lrck_d <= lrck;
            r_cnt    <= w_cnt_nxt;
            r_sr     <= w_sr_nxt;
        end
    end

    // A completed frame is dropped, never overwritten, while the consumer stalls.
    always_ff @(posedge bck or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_l  <= 16'd0;
            r_frame_r  <= 16'd0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
            r_sync_err <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_sync_err <= w_err;
            r_overrun  <= w_done & r_valid & ~frame_ready;
            if (w_load) begin
                r_frame_l <= w_sr_nxt[31:16];
                r_frame_r <= w_sr_nxt[15:0];
                r_valid   <= 1'b1;
            end else if (frame_ready) begin
                r_valid <= 1'b0;
            end
            if (w_err || (w_state_nxt == SYNC)) begin
                r_locked <= 1'b0;
            end else if (w_done) begin
                r_locked <= 1'b1;
            end
        end
    end

`ifdef LJ16_MUTE_DETECT_EN
    logic [6:0] r_zcnt;
    logic       r_mute;
    logic       w_zero;

    assign w_zero = (w_sr_nxt == 32'd0);

    // Dropped frames still count: detection follows the stream, not the consumer.
    always_ff @(posedge bck or negedge rst_n) begin
        if (!rst_n) begin
            r_zcnt <= 7'd0;
            r_mute <= 1'b0;
        end else if (w_done) begin
            if (w_zero) begin
                if (r_zcnt != 7'd64) begin
                    r_zcnt <= r_zcnt + 7'd1;
                end
                if (r_zcnt == 7'd63) begin
                    r_mute <= 1'b1;
                end
            end else begin
                r_zcnt <= 7'd0;
                r_mute <= 1'b0;
            end
        end
    end

    assign mute = r_mute;
`else
    assign mute = 1'b0;
`endif

    assign frame_l     = r_frame_l;
    assign frame_r     = r_frame_r;
    assign frame_valid = r_valid;
    assign locked      = r_locked;
    assign sync_err    = r_sync_err;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_lj16_frame_capture.sv
// Directed bench for lj16_frame_capture with a channel-level reference model.
module tb_lj16_frame_capture;

    logic        bck = 1'b0;
    logic        rst_n = 1'b0;
    logic        lrck = 1'b0;
    logic        data = 1'b0;
    logic        frame_ready = 1'b1;
    logic [15:0] frame_l;
    logic [15:0] frame_r;
    logic        frame_valid;
    logic        locked;
    logic        sync_err;
    logic        overrun;
    logic        mute;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef LJ16_MUTE_DETECT_EN
    localparam bit MUTE_EN = 1'b1;
`else
    localparam bit MUTE_EN = 1'b0;
`endif

    lj16_frame_capture dut (
        .bck         (bck),
        .rst_n       (rst_n),
        .lrck        (lrck),
        .data        (data),
        .frame_ready (frame_ready),
        .frame_l     (frame_l),
        .frame_r     (frame_r),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err),
        .overrun     (overrun),
        .mute        (mute)
    );

    always #5 bck = ~bck;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: channels are bit queues, judged only by length and lrck level.
    bit          m_prev = 1'b0;
    int          m_ch = -1;
    bit          m_q[$];
    logic [15:0] m_lw = 16'd0;
    int          m_zc = 0;
    logic [15:0] e_l = 16'd0;
    logic [15:0] e_r = 16'd0;
    logic        e_v = 1'b0;
    logic        e_lock = 1'b0;
    logic        e_err = 1'b0;
    logic        e_ovr = 1'b0;
    logic        e_mute = 1'b0;

    function automatic logic [15:0] pack(input bit q[$]);
        logic [15:0] w = 16'd0;
        foreach (q[i]) w = {w[14:0], q[i]};
        return w;
    endfunction

    always @(posedge bck or negedge rst_n) begin
        if (!rst_n) begin
            m_prev = 1'b0; m_ch = -1; m_q.delete(); m_zc = 0;
            e_l = 16'd0; e_r = 16'd0; e_v = 1'b0; e_lock = 1'b0;
            e_err = 1'b0; e_ovr = 1'b0; e_mute = 1'b0;
        end else begin
            bit edge_s, err, done;
            logic [15:0] rw;
            edge_s = (lrck != m_prev);
            err = 1'b0; done = 1'b0; rw = 16'd0;
            if (m_ch < 0) begin
                if (edge_s && lrck) begin m_ch = 0; m_q = {data}; end
            end else if (edge_s) begin
                if (m_q.size() == 16 && lrck == (m_ch == 1)) begin
                    if (m_ch == 0) m_lw = pack(m_q);
                    m_ch = 1 - m_ch; m_q = {data};
                end else begin
                    err = 1'b1;
                    if (lrck) begin m_ch = 0; m_q = {data}; end
                    else begin m_ch = -1; m_q.delete(); end
                end
            end else if (m_q.size() == 16) begin
                err = 1'b1; m_ch = -1; m_q.delete();
            end else begin
                m_q.push_back(data);
                if (m_ch == 1 && m_q.size() == 16) begin
                    done = 1'b1; rw = pack(m_q);
                end
            end
            m_prev = lrck;
            e_err = err;
            e_ovr = done && e_v && !frame_ready;
            if (done && (!e_v || frame_ready)) begin
                e_l = m_lw; e_r = rw; e_v = 1'b1;
            end else if (frame_ready) begin
                e_v = 1'b0;
            end
            if (err || m_ch < 0) e_lock = 1'b0;
            else if (done) e_lock = 1'b1;
            if (MUTE_EN && done) begin
                if (m_lw == 16'd0 && rw == 16'd0) begin
                    m_zc++;
                    if (m_zc >= 64) e_mute = 1'b1;
                end else begin
                    m_zc = 0; e_mute = 1'b0;
                end
            end
        end
    end

    always @(negedge bck) begin
        chk("cyc_frame_l", frame_l, e_l);
        chk("cyc_frame_r", frame_r, e_r);
        chk("cyc_frame_valid", {15'd0, frame_valid}, {15'd0, e_v});
        chk("cyc_locked", {15'd0, locked}, {15'd0, e_lock});
        chk("cyc_sync_err", {15'd0, sync_err}, {15'd0, e_err});
        chk("cyc_overrun", {15'd0, overrun}, {15'd0, e_ovr});
        chk("cyc_mute", {15'd0, mute}, {15'd0, e_mute});
    end

    task automatic bitc(input logic l, input logic d);
        lrck = l; data = d;
        @(negedge bck); #1;
    endtask

    task automatic send_bits(input logic l, input logic [15:0] w,
                             input int lo, input int hi);
        for (int i = lo; i <= hi; i++) bitc(l, w[15-i]);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_bits(1'b1, l, 0, 15);
        send_bits(1'b0, r, 0, 15);
    endtask

    initial begin
        #2;
        chk("rst_valid", {15'd0, frame_valid}, 16'd0);
        chk("rst_frame_l", frame_l, 16'd0);
        chk("rst_locked", {15'd0, locked}, 16'd0);
        @(negedge bck); @(negedge bck); #1;
        rst_n = 1'b1;
        repeat (3) bitc(1'b0, 1'b0);

        send_frame(16'h8001, 16'h7FFE);
        chk("t1_valid", {15'd0, frame_valid}, 16'd1);
        chk("t1_frame_l", frame_l, 16'h8001);
        chk("t1_frame_r", frame_r, 16'h7FFE);
        chk("t1_locked", {15'd0, locked}, 16'd1);

        send_bits(1'b1, 16'h1234, 0, 0);
        chk("t2_consumed", {15'd0, frame_valid}, 16'd0);
        frame_ready = 1'b0;
        send_bits(1'b1, 16'h1234, 1, 15);
        send_bits(1'b0, 16'h5678, 0, 15);
        chk("t2_valid", {15'd0, frame_valid}, 16'd1);
        chk("t2_frame_l", frame_l, 16'h1234);
        send_frame(16'hAAAA, 16'h5555);
        chk("t2_overrun", {15'd0, overrun}, 16'd1);
        chk("t2_held_l", frame_l, 16'h1234);
        chk("t2_held_r", frame_r, 16'h5678);
        frame_ready = 1'b1;
        send_bits(1'b1, 16'h3333, 0, 0);
        chk("t2_cleared", {15'd0, frame_valid}, 16'd0);
        chk("t2_ovr_once", {15'd0, overrun}, 16'd0);

        send_bits(1'b1, 16'h3333, 1, 15);
        send_bits(1'b0, 16'hCCCC, 0, 11);
        send_bits(1'b1, 16'h0F0F, 0, 0);
        chk("t3_sync_err", {15'd0, sync_err}, 16'd1);
        chk("t3_no_frame", {15'd0, frame_valid}, 16'd0);
        send_bits(1'b1, 16'h0F0F, 1, 15);
        send_bits(1'b0, 16'hF0F0, 0, 15);
        chk("t3_frame_l", frame_l, 16'h0F0F);
        chk("t3_frame_r", frame_r, 16'hF0F0);

        send_bits(1'b1, 16'hFFFF, 0, 15);
        bitc(1'b1, 1'b1);
        chk("t4_sync_err", {15'd0, sync_err}, 16'd1);
        chk("t4_unlock", {15'd0, locked}, 16'd0);
        repeat (3) bitc(1'b1, 1'b0);
        repeat (3) bitc(1'b0, 1'b1);
        chk("t4_quiet", {15'd0, sync_err}, 16'd0);

        frame_ready = 1'b0;
        send_frame(16'hBEEF, 16'hCAFE);
        chk("t5_valid", {15'd0, frame_valid}, 16'd1);
        send_bits(1'b1, 16'h1357, 0, 7);
        rst_n = 1'b0; lrck = 1'b0;
        #1;
        chk("t5_rst_valid", {15'd0, frame_valid}, 16'd0);
        chk("t5_rst_l", frame_l, 16'd0);
        chk("t5_rst_r", frame_r, 16'd0);
        chk("t5_rst_locked", {15'd0, locked}, 16'd0);
        @(negedge bck); @(negedge bck); #1;
        rst_n = 1'b1;
        frame_ready = 1'b1;
        repeat (2) bitc(1'b0, 1'b0);
        send_frame(16'h0001, 16'h0002);
        chk("t5_frame_l", frame_l, 16'h0001);
        chk("t5_frame_r", frame_r, 16'h0002);

        repeat (63) send_frame(16'h0000, 16'h0000);
        chk("t6_mute_63", {15'd0, mute}, 16'd0);
        send_frame(16'h0000, 16'h0000);
        chk("t6_mute_64", {15'd0, mute}, {15'd0, MUTE_EN});
        send_frame(16'h0000, 16'h0001);
        chk("t6_unmute", {15'd0, mute}, 16'd0);
        repeat (20) bitc(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
